updown_counter_7seg_mux: RTL and testbench

//  Parametrised multi-digit synchronous up/down counter with multiplexed 7-segment drive.
//  - Generalises the single-digit hex down counter: N digits, radix 10 or 16, direction

---
 rtl/updown_counter_7seg_mux.sv | 146 ++++++++++++++
 tb/tb_updown_counter_7seg_mux.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/updown_counter_7seg_mux.sv
// Multi-digit up/down counter (BCD or hex digits) with a time-multiplexed,
// active-low 7-segment display driver. One shared segment bus is scanned
// across DIGITS active-low digit selects.
module updown_counter_7seg_mux #(
    parameter int DIGITS   = 4,
    parameter int RADIX    = 10,
    parameter int SCAN_DIV = 1000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  up_dn,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   count,
    output logic                  tc,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     an
);

    localparam int W      = 4 * DIGITS;
    localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [3:0]        DIG_MAX   = 4'(RADIX - 1);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DIGITS - 1);

    logic [W-1:0]        count_reg, count_next;
    logic                tc_reg, tc_next;
    logic [SCAN_W-1:0]   scan_reg, scan_next;
    logic [IDX_W-1:0]    idx_reg, idx_next;

    logic [W-1:0]        load_clamped;
    logic [W-1:0]        stepped;
    // chain[k] = digit k receives a carry/borrow; chain[DIGITS] = full wrap
    logic [DIGITS:0]     chain;
    logic [3:0]          digit_arr [DIGITS];
    logic [3:0]          cur_digit;

    assign chain[0] = 1'b1;

    // Per-digit load clamping and one-cycle ripple step
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            logic [3:0] d_cur;
            logic [3:0] d_ld;
            logic       at_lim;

            assign d_cur  = count_reg[4*gi +: 4];
            assign d_ld   = load_val[4*gi +: 4];
            assign at_lim = up_dn ? (d_cur == DIG_MAX) : (d_cur == 4'd0);

            // Out-of-range load digits are forced to 0
            assign load_clamped[4*gi +: 4] = (d_ld > DIG_MAX) ? 4'd0 : d_ld;

            assign chain[gi+1] = chain[gi] & at_lim;

            assign stepped[4*gi +: 4] = !chain[gi] ? d_cur :
                                        at_lim     ? (up_dn ? 4'd0 : DIG_MAX) :
                                        up_dn      ? d_cur + 4'd1 : d_cur - 4'd1;

            assign digit_arr[gi] = d_cur;
        end
    endgenerate

    // Next count/tc: load beats enable; tc only on the wrapping step
    always_comb begin
        count_next = count_reg;
        tc_next    = 1'b0;
        if (load) begin
            count_next = load_clamped;
        end else if (en) begin
            count_next = stepped;
            tc_next    = chain[DIGITS];
        end
    end

    // Count and terminal-count registers
    always_ff @(posedge clk) begin
        if (reset) begin
            count_reg <= '0;
            tc_reg    <= 1'b0;
        end else begin
            count_reg <= count_next;
            tc_reg    <= tc_next;
        end
    end

    // Free-running scan divider and digit index
    always_comb begin
        scan_next = scan_reg + SCAN_W'(1);
        idx_next  = idx_reg;
        if (scan_reg == SCAN_LAST) begin
            scan_next = '0;
            idx_next  = (idx_reg == IDX_LAST) ? '0 : idx_reg + IDX_W'(1);
        end
    end

    // Scan state registers
    always_ff @(posedge clk) begin
        if (reset) begin
            scan_reg <= '0;
            idx_reg  <= '0;
        end else begin
            scan_reg <= scan_next;
            idx_reg  <= idx_next;
        end
    end

    assign cur_digit = digit_arr[idx_reg];

    // Active-low digit select: only the scanned digit is low
    always_comb begin
        an          = '1;
        an[idx_reg] = 1'b0;
    end

    // Active-low segment decode {g,f,e,d,c,b,a} of the scanned digit
    always_comb begin
        seg = 7'h7F;
        case (cur_digit)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            4'hF: seg = 7'h0E;
            default: seg = 7'h7F;
        endcase
    end

    assign count = count_reg;
    assign tc    = tc_reg;

endmodule

// File: tb/tb_updown_counter_7seg_mux.sv
// Scoreboard bench: instance 0 is BCD (SCAN_DIV=3), instance 1 is hex (SCAN_DIV=1).
// Stimulus pushes expected values tagged with the cycle they must appear in;
// a negedge monitor pops and compares them against the addressed instance.
module tb_updown_counter_7seg_mux;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_i  [2];
    logic        en_i     [2];
    logic        ud_i     [2];
    logic        load_i   [2];
    logic [15:0] lv_i     [2];
    logic [15:0] count_o  [2];
    logic        tc_o     [2];
    logic [6:0]  seg_o    [2];
    logic [3:0]  an_o     [2];

    updown_counter_7seg_mux #(.DIGITS(4), .RADIX(10), .SCAN_DIV(3)) dut_bcd (
        .clk(clk), .reset(reset_i[0]), .en(en_i[0]), .up_dn(ud_i[0]),
        .load(load_i[0]), .load_val(lv_i[0]), .count(count_o[0]), .tc(tc_o[0]),
        .seg(seg_o[0]), .an(an_o[0])
    );

    updown_counter_7seg_mux #(.DIGITS(4), .RADIX(16), .SCAN_DIV(1)) dut_hex (
        .clk(clk), .reset(reset_i[1]), .en(en_i[1]), .up_dn(ud_i[1]),
        .load(load_i[1]), .load_val(lv_i[1]), .count(count_o[1]), .tc(tc_o[1]),
        .seg(seg_o[1]), .an(an_o[1])
    );

    typedef struct {
        int          cyc;
        int          w;
        logic [15:0] c;
        logic        tc;
        bit          chk;
        logic [3:0]  an;
        logic [6:0]  seg;
    } exp_t;

    exp_t  sb[$];
    string name_q[$];
    int    cyc   = 0;
    int    total = 0;
    int    bad   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare every expectation due in the current cycle
    exp_t  m_e;
    string m_nm;
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            m_e  = sb.pop_front();
            m_nm = name_q.pop_front();
            total++;
            if (count_o[m_e.w] !== m_e.c || tc_o[m_e.w] !== m_e.tc ||
                (m_e.chk && (an_o[m_e.w] !== m_e.an || seg_o[m_e.w] !== m_e.seg))) begin
                bad++;
                $display("FAIL %s dut%0d: got count=%h tc=%b an=%b seg=%h, want count=%h tc=%b an=%b seg=%h (scan %s)",
                         m_nm, m_e.w, count_o[m_e.w], tc_o[m_e.w], an_o[m_e.w], seg_o[m_e.w],
                         m_e.c, m_e.tc, m_e.an, m_e.seg, m_e.chk ? "checked" : "ignored");
            end else begin
                $display("ok   %s dut%0d: count=%h tc=%b an=%b seg=%h",
                         m_nm, m_e.w, count_o[m_e.w], tc_o[m_e.w], an_o[m_e.w], seg_o[m_e.w]);
            end
        end
    end

    // One cycle of stimulus on instance w; the other instance idles
    task automatic drive(input int w, input logic rst, input logic ld, input logic e,
                         input logic ud, input logic [15:0] lv,
                         input logic [15:0] xc, input logic xtc, input bit chk,
                         input logic [3:0] xan, input logic [6:0] xseg, input string nm);
        exp_t x;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            reset_i[k] = 1'b0;
            en_i[k]    = 1'b0;
            load_i[k]  = 1'b0;
        end
        reset_i[w] = rst;
        load_i[w]  = ld;
        en_i[w]    = e;
        ud_i[w]    = ud;
        lv_i[w]    = lv;
        x.cyc = cyc + 1;
        x.w   = w;
        x.c   = xc;
        x.tc  = xtc;
        x.chk = chk;
        x.an  = xan;
        x.seg = xseg;
        sb.push_back(x);
        name_q.push_back(nm);
    endtask

    task automatic st(input int w, input logic rst, input logic ld, input logic e,
                      input logic ud, input logic [15:0] lv,
                      input logic [15:0] xc, input logic xtc, input string nm);
        drive(w, rst, ld, e, ud, lv, xc, xtc, 1'b0, 4'hF, 7'h7F, nm);
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            reset_i[k] = 1'b0; en_i[k] = 1'b0; ud_i[k] = 1'b0;
            load_i[k]  = 1'b0; lv_i[k] = 16'h0;
        end

        // Reset with en/load asserted, two cycles each instance
        for (int w = 0; w < 2; w++) begin
            drive(w, 1, 1, 1, 1, 16'h5555, 16'h0000, 0, 1, 4'b1110, 7'h40, "reset_a");
            drive(w, 1, 1, 1, 1, 16'h5555, 16'h0000, 0, 1, 4'b1110, 7'h40, "reset_b");
        end

        // BCD up wrap
        st(0, 0, 1, 0, 1, 16'h9998, 16'h9998, 0, "bcd_load");
        st(0, 0, 0, 1, 1, 16'h0000, 16'h9999, 0, "bcd_up_9999");
        st(0, 0, 0, 1, 1, 16'h0000, 16'h0000, 1, "bcd_up_wrap");
        st(0, 0, 0, 1, 1, 16'h0000, 16'h0001, 0, "bcd_up_0001");
        // Direction change, then BCD down wrap
        st(0, 0, 0, 1, 0, 16'h0000, 16'h0000, 0, "bcd_dn_0000");
        st(0, 0, 0, 1, 0, 16'h0000, 16'h9999, 1, "bcd_dn_wrap");
        st(0, 0, 0, 1, 0, 16'h0000, 16'h9998, 0, "bcd_dn_9998");
        // Load beats enable, digit clamp, then hold
        st(0, 0, 1, 1, 1, 16'h12A4, 16'h1204, 0, "bcd_load_clamp");
        st(0, 0, 0, 0, 1, 16'h0000, 16'h1204, 0, "bcd_hold");
        // Carry ripple across middle digits
        st(0, 0, 1, 0, 1, 16'h0999, 16'h0999, 0, "bcd_load_0999");
        st(0, 0, 0, 1, 1, 16'h0000, 16'h1000, 0, "bcd_ripple");

        // Hex down wrap
        st(1, 0, 1, 0, 0, 16'h0001, 16'h0001, 0, "hex_load");
        st(1, 0, 0, 1, 0, 16'h0000, 16'h0000, 0, "hex_dn_0000");
        st(1, 0, 0, 1, 0, 16'h0000, 16'hFFFF, 1, "hex_dn_wrap");
        st(1, 0, 0, 1, 0, 16'h0000, 16'hFFFE, 0, "hex_dn_fffe");
        // Hex accepts A..F on load; up wrap
        st(1, 0, 1, 0, 1, 16'hFFFF, 16'hFFFF, 0, "hex_load_ffff");
        st(1, 0, 0, 1, 1, 16'h0000, 16'h0000, 1, "hex_up_wrap");
        st(1, 0, 1, 1, 1, 16'h12A4, 16'h12A4, 0, "hex_load_12a4");

        // Hex scan with SCAN_DIV=1: index moves every clock
        drive(1, 1, 0, 0, 1, 16'h0000, 16'h0000, 0, 1, 4'b1110, 7'h40, "hex_scan_rst");
        drive(1, 0, 0, 0, 1, 16'h0000, 16'h0000, 0, 1, 4'b1101, 7'h40, "hex_scan_1");
        drive(1, 0, 0, 0, 1, 16'h0000, 16'h0000, 0, 1, 4'b1011, 7'h40, "hex_scan_2");

        // BCD mid-count reset, then scan of 1234 with SCAN_DIV=3
        drive(0, 1, 1, 1, 1, 16'h9999, 16'h0000, 0, 1, 4'b1110, 7'h40, "scan_rst");
        drive(0, 0, 1, 0, 1, 16'h1234, 16'h1234, 0, 1, 4'b1110, 7'h19, "scan_d0_a");
        drive(0, 0, 0, 0, 1, 16'h0000, 16'h1234, 0, 1, 4'b1110, 7'h19, "scan_d0_b");
        for (int r = 0; r < 3; r++)
            drive(0, 0, 0, 0, 1, 16'h0000, 16'h1234, 0, 1, 4'b1101, 7'h30, "scan_d1");
        for (int r = 0; r < 3; r++)
            drive(0, 0, 0, 0, 1, 16'h0000, 16'h1234, 0, 1, 4'b1011, 7'h24, "scan_d2");
        for (int r = 0; r < 3; r++)
            drive(0, 0, 0, 0, 1, 16'h0000, 16'h1234, 0, 1, 4'b0111, 7'h79, "scan_d3");
        drive(0, 0, 0, 0, 1, 16'h0000, 16'h1234, 0, 1, 4'b1110, 7'h19, "scan_wrap");

        // Drain the scoreboard within a bounded number of cycles
        for (int t = 0; t < 20 && sb.size() > 0; t++) @(negedge clk);
        if (sb.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d expectations left, want 0", sb.size());
        end
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
